// File: rtl/switch_press_decoder.sv
// switch_press_decoder: turns a debounced switch level into
// short-press, long-press and double-click pulses plus a long-hold level.
module switch_press_decoder #(
    parameter int LONG_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 6250000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_switch,
    output logic o_short,
    output logic o_long,
    output logic o_double,
    output logic o_held
);

    localparam int MAX_CYCLES =
        (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int CW =
        (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_WAIT_GAP,
        S_PRESS2,
        S_LONG_HELD
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;

    // Press classifier: input changes take priority over terminal counts,
    // every state change clears the counter, pulses last one cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            o_short  <= 1'b0;
            o_long   <= 1'b0;
            o_double <= 1'b0;
            o_held   <= 1'b0;
        end else begin
            o_short  <= 1'b0;
            o_long   <= 1'b0;
            o_double <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_switch) begin
                        r_state <= S_PRESS1;
                        r_count <= '0;
                    end
                end
                S_PRESS1: begin
                    if (!i_switch) begin
                        r_state <= S_WAIT_GAP;
                        r_count <= '0;
                    end else if (r_count == LONG_LAST) begin
                        r_state <= S_LONG_HELD;
                        r_count <= '0;
                        o_long  <= 1'b1;
                        o_held  <= 1'b1;
                    end else begin
                        r_count <= r_count + ONE;
                    end
                end
                S_WAIT_GAP: begin
                    if (i_switch) begin
                        r_state <= S_PRESS2;
                        r_count <= '0;
                    end else if (r_count == GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                        o_short <= 1'b1;
                    end else begin
                        r_count <= r_count + ONE;
                    end
                end
                S_PRESS2: begin
                    if (!i_switch) begin
                        r_state  <= S_IDLE;
                        r_count  <= '0;
                        o_double <= 1'b1;
                    end else if (r_count == LONG_LAST) begin
                        r_state  <= S_LONG_HELD;
                        r_count  <= '0;
                        o_double <= 1'b1;
                        o_held   <= 1'b1;
                    end else begin
                        r_count <= r_count + ONE;
                    end
                end
                S_LONG_HELD: begin
                    if (!i_switch) begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                        o_held  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_count <= '0;
                    o_held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_press_decoder.sv
// tb_switch_press_decoder: segment table, hand sequences and random
// level runs checked against a run-length press classifier.
module tb_switch_press_decoder;

    localparam int L = 20;
    localparam int G = 8;

    logic i_clk = 1'b0;
    logic i_rst;
    logic i_switch;
    logic o_short;
    logic o_long;
    logic o_double;
    logic o_held;

    int errors = 0;
    int checks = 0;

    int c_short, c_long, c_double, c_held;

    bit e_short, e_long, e_double, e_held;
    bit m_hold;
    bit seq[$];

    typedef struct {
        bit sw;
        int n;
        int s;
        int l;
        int d;
        int h;
    } seg_t;

    seg_t segs[$];

    switch_press_decoder #(
        .LONG_CYCLES(L),
        .GAP_CYCLES (G)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_switch(i_switch),
        .o_short (o_short),
        .o_long  (o_long),
        .o_double(o_double),
        .o_held  (o_held)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic act,
                         input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act,
                             input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        seq.delete();
        m_hold   = 1'b0;
        e_short  = 1'b0;
        e_long   = 1'b0;
        e_double = 1'b0;
        e_held   = 1'b0;
    endfunction

    // Classify the samples of the current press sequence by run lengths:
    // H^(L+1) long, H+ L^(G+1) short, H+ L+ H^(L+1) or H+ L+ H+ L double.
    function automatic void model_step(input bit s);
        int runs[$];
        e_short  = 1'b0;
        e_long   = 1'b0;
        e_double = 1'b0;
        if (m_hold) begin
            if (!s) m_hold = 1'b0;
        end else if (seq.size() == 0) begin
            if (s) seq.push_back(1'b1);
        end else begin
            seq.push_back(s);
            runs.push_back(1);
            for (int i = 1; i < seq.size(); i++) begin
                if (seq[i] == seq[i-1]) runs[runs.size()-1]++;
                else runs.push_back(1);
            end
            if (runs.size() == 1 && runs[0] == L + 1) begin
                e_long = 1'b1;
                m_hold = 1'b1;
                seq.delete();
            end else if (runs.size() == 2 && runs[1] == G + 1) begin
                e_short = 1'b1;
                seq.delete();
            end else if (runs.size() == 3 && runs[2] == L + 1) begin
                e_double = 1'b1;
                m_hold   = 1'b1;
                seq.delete();
            end else if (runs.size() == 4) begin
                e_double = 1'b1;
                seq.delete();
            end
        end
        e_held = m_hold;
    endfunction

    task automatic tick(input bit s);
        i_switch = s;
        @(posedge i_clk);
        if (i_rst) model_reset();
        else model_step(s);
        #1;
        check("short", o_short, e_short);
        check("long", o_long, e_long);
        check("double", o_double, e_double);
        check("held", o_held, e_held);
        check("exclusive",
              ($countones({o_short, o_long, o_double}) <= 1), 1'b1);
        c_short  += int'(o_short);
        c_long   += int'(o_long);
        c_double += int'(o_double);
        c_held   += int'(o_held);
    endtask

    task automatic clr_counts();
        c_short  = 0;
        c_long   = 0;
        c_double = 0;
        c_held   = 0;
    endtask

    initial begin
        bit lvl;
        int len;

        i_rst    = 1'b1;
        i_switch = 1'b1;
        model_reset();
        clr_counts();

        // reset with switch pressed: no pulses, then a fresh long press
        repeat (5) tick(1'b1);
        check_int("rst_pulses", c_short + c_long + c_double + c_held, 0);
        i_rst = 1'b0;
        clr_counts();
        repeat (20) tick(1'b1);
        check_int("rst_no_long_early", c_long, 0);
        tick(1'b1);
        check("rst_long_21", o_long, 1'b1);
        tick(1'b0);
        repeat (12) tick(1'b0);
        check_int("rst_long_once", c_long, 1);
        check_int("rst_no_short", c_short, 0);

        // async reset clears a pulse that is currently high
        repeat (21) tick(1'b1);
        check("pre_abort_long", o_long, 1'b1);
        i_rst = 1'b1;
        #1;
        check("abort_long", o_long, 1'b0);
        check("abort_held", o_held, 1'b0);
        model_reset();
        #1;
        i_rst = 1'b0;
        clr_counts();
        repeat (12) tick(1'b0);
        check_int("abort_no_pulse", c_short + c_long + c_double, 0);

        // segments: {level, edges, shorts, longs, doubles, held cycles}
        segs.push_back('{1'b1, 5, 0, 0, 0, 0});
        segs.push_back('{1'b0, 8, 0, 0, 0, 0});
        segs.push_back('{1'b0, 1, 1, 0, 0, 0});
        segs.push_back('{1'b0, 3, 0, 0, 0, 0});
        segs.push_back('{1'b1, 20, 0, 0, 0, 0});
        segs.push_back('{1'b1, 1, 0, 1, 0, 1});
        segs.push_back('{1'b1, 9, 0, 0, 0, 9});
        segs.push_back('{1'b0, 1, 0, 0, 0, 0});
        segs.push_back('{1'b0, 12, 0, 0, 0, 0});
        segs.push_back('{1'b1, 20, 0, 0, 0, 0});
        segs.push_back('{1'b0, 9, 1, 0, 0, 0});
        segs.push_back('{1'b0, 2, 0, 0, 0, 0});
        segs.push_back('{1'b1, 21, 0, 1, 0, 1});
        segs.push_back('{1'b0, 13, 0, 0, 0, 0});
        segs.push_back('{1'b1, 5, 0, 0, 0, 0});
        segs.push_back('{1'b0, 4, 0, 0, 0, 0});
        segs.push_back('{1'b1, 5, 0, 0, 0, 0});
        segs.push_back('{1'b0, 1, 0, 0, 1, 0});
        segs.push_back('{1'b0, 12, 0, 0, 0, 0});
        segs.push_back('{1'b1, 5, 0, 0, 0, 0});
        segs.push_back('{1'b0, 4, 0, 0, 0, 0});
        segs.push_back('{1'b1, 20, 0, 0, 0, 0});
        segs.push_back('{1'b1, 1, 0, 0, 1, 1});
        segs.push_back('{1'b1, 4, 0, 0, 0, 4});
        segs.push_back('{1'b0, 1, 0, 0, 0, 0});
        segs.push_back('{1'b0, 12, 0, 0, 0, 0});
        segs.push_back('{1'b1, 5, 0, 0, 0, 0});
        segs.push_back('{1'b0, 9, 1, 0, 0, 0});
        segs.push_back('{1'b1, 1, 0, 0, 0, 0});
        segs.push_back('{1'b0, 9, 1, 0, 0, 0});
        segs.push_back('{1'b0, 2, 0, 0, 0, 0});
        segs.push_back('{1'b1, 5, 0, 0, 0, 0});
        segs.push_back('{1'b0, 8, 0, 0, 0, 0});
        segs.push_back('{1'b1, 3, 0, 0, 0, 0});
        segs.push_back('{1'b0, 1, 0, 0, 1, 0});
        segs.push_back('{1'b0, 12, 0, 0, 0, 0});

        foreach (segs[k]) begin
            clr_counts();
            repeat (segs[k].n) tick(segs[k].sw);
            check_int($sformatf("seg%0d_short", k), c_short, segs[k].s);
            check_int($sformatf("seg%0d_long", k), c_long, segs[k].l);
            check_int($sformatf("seg%0d_double", k), c_double, segs[k].d);
            check_int($sformatf("seg%0d_held", k), c_held, segs[k].h);
        end

        // random level runs with occasional resets
        lvl = 1'b1;
        for (int r = 0; r < 160; r++) begin
            len = $urandom_range(1, 24);
            if ($urandom_range(0, 19) == 0) begin
                i_rst = 1'b1;
                tick(lvl);
                i_rst = 1'b0;
            end
            repeat (len) tick(lvl);
            lvl = ~lvl;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/switch_press_decoder.md
# switch_press_decoder

Classifies presses of one debounced, active-high switch level into short-press, long-press and double-click events. It sits directly downstream of the debounce filter and replaces the plain release-edge toggle for UI logic that needs richer input. Each event appears as a single-cycle pulse, and a level output flags an ongoing long hold.

## Interface

- LONG_CYCLES, 25000000, press duration in clock cycles that qualifies as a long press; must be ≥2
- GAP_CYCLES, 6250000, maximum released interval in cycles between two presses of a double click; must be ≥2
- i_clk  input  1  system clock; all logic on rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_switch  input  1  debounced switch level, 1 = pressed; already synchronous to i_clk
- o_short  output  1  one-cycle pulse: single short press completed
- o_long  output  1  one-cycle pulse: press held LONG_CYCLES
- o_double  output  1  one-cycle pulse: second press of a double click detected
- o_held  output  1  level: high while in LONG_HELD

## Operation

- Counter r_count has width $clog2(max(LONG_CYCLES, GAP_CYCLES)). It clears on every state change and increments by 1 while staying in a counting state. It never wraps, because each state exits at its terminal count.
- States and transitions, evaluated at each rising edge on the sampled i_switch:
  - IDLE: i_switch=1 → PRESS1. Otherwise stay.
  - PRESS1: i_switch=0 → WAIT_GAP. Else, if r_count==LONG_CYCLES-1 → LONG_HELD and pulse o_long. Else increment.
  - WAIT_GAP: i_switch=1 → PRESS2. Else, if r_count==GAP_CYCLES-1 → IDLE and pulse o_short. Else increment.
  - PRESS2: i_switch=0 → IDLE and pulse o_double. Else, if r_count==LONG_CYCLES-1 → LONG_HELD and pulse o_double. Else increment. o_long is never issued from PRESS2.
  - LONG_HELD: i_switch=0 → IDLE. Otherwise stay. No counting.
- Simultaneous events: the input change always wins over the terminal count.
  - Release at the long terminal edge in PRESS1 → WAIT_GAP, no o_long.
  - Press at the gap terminal edge in WAIT_GAP → PRESS2, no o_short.
- At most one of o_short, o_long and o_double is high in any cycle.
- Exactly one event is emitted per press sequence: one short, one long, or one double.

## Timing

- Reset (async assert, synchronous-safe deassert): state=IDLE, r_count=0, o_short=o_long=o_double=o_held=0.
- Reset asserted mid-sequence aborts it. No pulse is emitted, and any pending pulse is cleared immediately.
- If i_switch is 1 at reset release, IDLE moves to PRESS1 on the first edge. That press is treated as new.
- All outputs are registered. A pulse is high in the cycle following the edge at which its transition is taken.
- Long press: i_switch is sampled 1 at edges N..N+LONG_CYCLES (N = edge IDLE→PRESS1). o_long is high for the cycle after edge N+LONG_CYCLES. o_held rises in that same cycle.
- o_held falls in the cycle after the edge that samples i_switch=0 in LONG_HELD.
- Short press: release sampled at edge M (→WAIT_GAP), then i_switch sampled 0 through edge M+GAP_CYCLES. o_short is high in the cycle after edge M+GAP_CYCLES.
- Double click: i_switch sampled 1 at any edge M+1..M+GAP_CYCLES moves to PRESS2. o_double follows the cycle after the second release, or after LONG_CYCLES of hold.
- Throughput: a new sequence can start on the edge after return to IDLE.

## Test plan

All scenarios use LONG_CYCLES=20 and GAP_CYCLES=8.

- Reset: assert i_rst with i_switch=1 for 5 cycles → all outputs 0, no pulse during reset. After deassert, hold i_switch=1 for 21 edges → o_long pulses once.
- Short press: i_switch=1 for 5 cycles, then 0 → o_short high for exactly 1 cycle, 8 edges after the release edge. o_long and o_double stay 0 throughout.
- Long press: i_switch=1 for 30 cycles → o_long pulses at the cycle after the 21st sampled-high edge. o_held is high from that cycle until 1 cycle after release. No o_short afterwards.
- Long boundary: high for exactly 20 sampled edges then release → no o_long; o_short after the gap. Repeat with 21 sampled edges → o_long, no o_short.
- Double click: press 5, release 4, press 5, release → o_double pulses 1 cycle after the second release edge. No o_short. Repeat with second press held 25 cycles → o_double at 20 cycles into the hold, o_held high until release, no o_long.
- Gap boundary: release held low through edge M+8, press at M+9 → o_short, then a new PRESS1 sequence. Press at M+8 instead → PRESS2 and no o_short.
